// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 10-bit sample -> 4-digit BCD, time-multiplexed onto
// a shared seven-segment decoder with optional leading-zero blanking.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   data_in[9:0]        unsigned sample, qualified by data_valid
//   data_valid          one-cycle strobe, dropped while busy
//   lz_blank            1 = blank leading zeros
//   busy                conversion in progress
//   dig_en[3:0]         active-low digit selects, bit 0 = ones
//   dec_en              decoder enable, 0 blanks the segments
//   dec_in[3:0]         BCD digit for the decoder
module seg_scan_ctrl #(
   parameter int DATA_W   = 10,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic              lz_blank,
   output logic              busy,
   output logic [3:0]        dig_en,
   output logic              dec_en,
   output logic [3:0]        dec_in
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int BCD_W = 16;
   localparam int SH_W  = BCD_W + DATA_W;
   localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_LOAD
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [3:0]          bit_q, bit_d;
   logic [3:0][3:0]     disp_q, disp_d;
   logic                busy_q, busy_d;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          idx_q, idx_d;
   logic [3:0]          dig_q, dig_d;
   logic                den_q, den_d;
   logic [3:0]          din_q, din_d;

   logic [BCD_W-1:0]    adj;
   logic [SH_W-1:0]     shifted;
   logic                zero_up;

   // Shift-and-add-3: correct each nibble before the shift so it
   // carries into the next decade instead of exceeding 9.
   always_comb begin
      adj     = '0;
      for (int n = 0; n < 4; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) begin
            adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
         end else begin
            adj[4*n +: 4] = bcd_q[4*n +: 4];
         end
      end
      shifted = {adj, bin_q} << 1;
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      bit_d   = bit_q;
      disp_d  = disp_q;
      unique case (state_q)
         S_IDLE: begin
            if (data_valid) begin
               bin_d   = data_in;
               bcd_d   = '0;
               bit_d   = '0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            bcd_d = shifted[SH_W-1:DATA_W];
            bin_d = shifted[DATA_W-1:0];
            bit_d = bit_q + 4'd1;
            if (bit_q == LAST_BIT) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            disp_d  = bcd_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Scan engine is free-running and never touched by the FSM, so a
   // new value lands mid-scan without disturbing the digit timing.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_TC) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   // All three outputs come from one register stage so the digit
   // select and segment data always switch on the same edge.
   always_comb begin
      zero_up = 1'b0;
      unique case (idx_q)
         2'd0: zero_up = 1'b0;
         2'd1: zero_up = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0)
                      && (disp_q[1] == 4'd0);
         2'd2: zero_up = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0);
         2'd3: zero_up = (disp_q[3] == 4'd0);
         default: zero_up = 1'b0;
      endcase
      dig_d = ~(4'b0001 << idx_q);
      din_d = disp_q[idx_q];
      den_d = !(lz_blank && zero_up);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         bit_q   <= '0;
         disp_q  <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         dig_q   <= 4'b1110;
         den_q   <= 1'b1;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         bit_q   <= bit_d;
         disp_q  <= disp_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dig_q   <= dig_d;
         den_q   <= den_d;
         din_q   <= din_d;
      end
   end

   assign busy   = busy_q;
   assign dig_en = dig_q;
   assign dec_en = den_q;
   assign dec_in = din_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl.
// u0 scans with SCAN_DIV=4, u1 with SCAN_DIV=2 for the wrap check.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] data_in;
   logic       data_valid;
   logic       lz_blank;

   logic       busy0, busy1;
   logic [3:0] dig0, dig1;
   logic       den0, den1;
   logic [3:0] din0, din1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DATA_W(10), .SCAN_DIV(4)) u0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .data_valid(data_valid), .lz_blank(lz_blank),
      .busy(busy0), .dig_en(dig0), .dec_en(den0), .dec_in(din0)
   );

   seg_scan_ctrl #(.DATA_W(10), .SCAN_DIV(2)) u1 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .data_valid(data_valid), .lz_blank(lz_blank),
      .busy(busy1), .dig_en(dig1), .dec_en(den1), .dec_in(din1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a posedge; the strobe is sampled at the next
   // edge (E0) and we return #1 after E0.
   task automatic strobe(input logic [9:0] v);
      data_in    = v;
      data_valid = 1'b1;
      @(posedge clk);
      #1 data_valid = 1'b0;
   endtask

   task automatic convert(input logic [9:0] v, input logic lz);
      @(posedge clk);
      #1 lz_blank = lz;
      strobe(v);
      repeat (12) @(posedge clk);
      #1;
   endtask

   // dg holds digit k in nibble k; en holds the dec_en expected at idx k.
   task automatic scan_check(input string tag, input logic [15:0] dg,
                             input logic [3:0] en);
      logic [3:0] prev;
      bit found;
      found = 1'b0;
      @(negedge clk);
      prev = dig0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (dig0 == 4'b1110 && prev != 4'b1110) found = 1'b1;
         else prev = dig0;
      end
      chk({tag, "_sync"}, 32'(found), 32'd1);
      if (found) begin
         for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            chk({tag, "_dig"}, 32'(dig0), 32'(4'(~(4'b0001 << k))));
            chk({tag, "_din"}, 32'(din0), 32'(dg[4*k +: 4]));
            chk({tag, "_den"}, 32'(den0), 32'(en[k]));
         end
      end
   endtask

   initial begin : main
      int n;
      logic [3:0] prev;
      bit found;
      logic [15:0] wdg;

      rst_n      = 1'b0;
      data_in    = '0;
      data_valid = 1'b0;
      lz_blank   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_dig", 32'(dig0), 32'hE);
      chk("rst_din", 32'(din0), 32'd0);
      chk("rst_den", 32'(den0), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset asserted mid-conversion
      strobe(10'd1023);
      repeat (4) @(posedge clk);
      #1 chk("conv_busy", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy0), 32'd0);
      chk("mrst_busy1", 32'(busy1), 32'd0);
      chk("mrst_dig", 32'(dig0), 32'hE);
      chk("mrst_din", 32'(din0), 32'd0);
      chk("mrst_den", 32'(den0), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      scan_check("rst_scan", 16'h0000, 4'b1111);

      // max value, busy length
      @(posedge clk);
      #1 lz_blank = 1'b0;
      strobe(10'd1023);
      n = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (busy0) n++;
      end
      chk("busy_len", 32'(n), 32'd11);
      scan_check("max", 16'h1023, 4'b1111);

      convert(10'd5, 1'b1);
      scan_check("blank5", 16'h0005, 4'b0001);
      convert(10'd0, 1'b1);
      scan_check("zero", 16'h0000, 4'b0001);
      convert(10'd1005, 1'b1);
      scan_check("inner0", 16'h1005, 4'b1111);

      // dropped strobe at E5
      @(posedge clk);
      #1 lz_blank = 1'b0;
      strobe(10'd123);
      repeat (4) @(posedge clk);
      #1 data_in = 10'd999;
      data_valid = 1'b1;
      @(posedge clk);
      #1 data_valid = 1'b0;
      chk("drop_e5", 32'(busy0), 32'd1);
      repeat (5) @(posedge clk);
      #1 chk("drop_e10", 32'(busy0), 32'd1);
      @(posedge clk);
      #1 chk("drop_e11", 32'(busy0), 32'd0);
      @(posedge clk);
      #1 chk("drop_e12", 32'(busy0), 32'd0);
      scan_check("drop", 16'h0123, 4'b1111);

      // strobe exactly at E12 is accepted
      @(posedge clk);
      #1;
      strobe(10'd777);
      repeat (11) @(posedge clk);
      #1 chk("acc_e11", 32'(busy0), 32'd0);
      data_in    = 10'd456;
      data_valid = 1'b1;
      @(posedge clk);
      #1 data_valid = 1'b0;
      chk("acc_e12", 32'(busy0), 32'd1);
      repeat (11) @(posedge clk);
      #1 chk("acc_e23", 32'(busy0), 32'd0);
      @(posedge clk);
      scan_check("acc", 16'h0456, 4'b1111);

      // SCAN_DIV=2 wrap on u1
      wdg   = 16'h0456;
      found = 1'b0;
      @(negedge clk);
      prev = dig1;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (dig1 == 4'b1110 && prev != 4'b1110) found = 1'b1;
         else prev = dig1;
      end
      chk("wrap_sync", 32'(found), 32'd1);
      if (found) begin
         for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("wrap_dig", 32'(dig1),
                32'(4'(~(4'b0001 << ((i / 2) % 4)))));
            chk("wrap_din", 32'(din1), 32'(wdg[4*((i/2)%4) +: 4]));
            chk("wrap_den", 32'(den1), 32'd1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
